// File: rtl/cla_pipe_adder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cla_pipe_adder_pkg                                                   |
// | Shared constants, op encoding and lookahead helper for the adder.    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package cla_pipe_adder_pkg;

    localparam int c_group_w = 16;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    function automatic bit params_legal(input int width, input int stages);
        int groups;
        groups = width / c_group_w;
        return (width % c_group_w == 0) && (width >= c_group_w) && (width <= 64)
            && (stages >= 1) && (stages <= groups) && (groups % stages == 0);
    endfunction

    // Two-level lookahead carry into position n of a (up to) 4-wide P/G set,
    // expanded as a flat sum of products so no carry ripples through.
    function automatic logic cla_carry(input logic ci, input logic [3:0] g,
                                       input logic [3:0] p, input int n);
        logic c;
        logic term;
        c = ci;
        for (int i = 0; i < n; i++) c = c & p[i];
        for (int i = 0; i < n; i++) begin
            term = g[i];
            for (int m = i + 1; m < n; m++) term = term & p[m];
            c = c | term;
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cla_group16.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cla_group16                                                          |
// | 16-bit carry-lookahead group: four 4-bit blocks, group P/G outputs.  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module cla_group16
    import cla_pipe_adder_pkg::*;
(
    input  logic [c_group_w-1:0] a,
    input  logic [c_group_w-1:0] b,
    input  logic                 cin,
    output logic [c_group_w-1:0] sum,
    output logic                 p,
    output logic                 g
);

    localparam int c_blk_w = 4;
    localparam int c_nblk  = c_group_w / c_blk_w;

    logic [c_group_w-1:0] w_p;
    logic [c_group_w-1:0] w_g;
    logic [c_group_w-1:0] w_c;
    logic [c_nblk-1:0]    w_bp;
    logic [c_nblk-1:0]    w_bg;
    logic [c_nblk-1:0]    w_bc;

    assign w_p = a ^ b;
    assign w_g = a & b;

    always_comb begin
        w_bp = '0;
        w_bg = '0;
        for (int k = 0; k < c_nblk; k++) begin
            w_bp[k] = &w_p[k*c_blk_w +: c_blk_w];
            w_bg[k] = cla_carry(1'b0, w_g[k*c_blk_w +: c_blk_w], w_p[k*c_blk_w +: c_blk_w], c_blk_w);
        end
    end

    always_comb begin
        w_bc = '0;
        w_c  = '0;
        for (int k = 0; k < c_nblk; k++) begin
            w_bc[k] = cla_carry(cin, w_bg, w_bp, k);
            for (int j = 0; j < c_blk_w; j++) begin
                w_c[k*c_blk_w + j] = cla_carry(w_bc[k], w_g[k*c_blk_w +: c_blk_w],
                                               w_p[k*c_blk_w +: c_blk_w], j);
            end
        end
    end

    assign sum = w_p ^ w_c;
    assign p   = &w_bp;
    assign g   = cla_carry(1'b0, w_bg, w_bp, c_nblk);

endmodule
`default_nettype wire

// File: rtl/cla_pipe_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cla_pipe_adder                                                       |
// | Pipelined add/subtract built from 16-bit CLA groups, valid/ready IO. |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module cla_pipe_adder
    import cla_pipe_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int c_ngroups = WIDTH / c_group_w;
    localparam int c_gps     = c_ngroups / STAGES;

    if (!params_legal(WIDTH, STAGES)) begin : g_param_check
        $fatal(1, "cla_pipe_adder: illegal WIDTH/STAGES combination");
    end

    logic [WIDTH-1:0]  r_sum [STAGES];
    logic [WIDTH-1:0]  r_a   [STAGES];
    logic [WIDTH-1:0]  r_b   [STAGES];
    logic [STAGES-1:0] r_vld;
    logic [STAGES-1:0] r_c;
    logic              r_ovf;
    logic              r_zero;

    logic [STAGES-1:0] w_adv;
    logic [STAGES-1:0] w_vin;
    logic [STAGES-1:0] w_nco;
    logic [WIDTH-1:0]  w_sa   [STAGES];
    logic [WIDTH-1:0]  w_sb   [STAGES];
    logic [WIDTH-1:0]  w_nsum [STAGES];
    logic              w_novf;
    logic              w_nzero;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0]     w_a;
        logic [WIDTH-1:0]     w_b;
        logic [WIDTH-1:0]     w_psum;
        logic [WIDTH-1:0]     w_ns;
        logic                 w_ci;
        logic [c_gps-1:0]     w_gp;
        logic [c_gps-1:0]     w_gg;
        logic [3:0]           w_gp4;
        logic [3:0]           w_gg4;
        logic [c_gps:0]       w_gc;
        logic [c_group_w-1:0] w_gsum [c_gps];

        // Operand inversion happens once at entry; later stages carry b'.
        if (k == 0) begin : g_head
            assign w_a    = a;
            assign w_b    = (sub == OP_SUB) ? ~b : b;
            assign w_ci   = (sub == OP_SUB) ? ~cin : cin;
            assign w_psum = '0;
        end else begin : g_body
            assign w_a    = r_a[k-1];
            assign w_b    = r_b[k-1];
            assign w_ci   = r_c[k-1];
            assign w_psum = r_sum[k-1];
        end

        for (genvar j = 0; j < c_gps; j++) begin : g_group
            localparam int c_lsb = (k*c_gps + j) * c_group_w;
            cla_group16 u_group (
                .a   (w_a[c_lsb +: c_group_w]),
                .b   (w_b[c_lsb +: c_group_w]),
                .cin (w_gc[j]),
                .sum (w_gsum[j]),
                .p   (w_gp[j]),
                .g   (w_gg[j])
            );
        end

        assign w_gp4 = 4'(w_gp);
        assign w_gg4 = 4'(w_gg);

        for (genvar j = 0; j <= c_gps; j++) begin : g_carry
            assign w_gc[j] = cla_carry(w_ci, w_gg4, w_gp4, j);
        end

        always_comb begin
            w_ns = w_psum;
            for (int j = 0; j < c_gps; j++) begin
                w_ns[(k*c_gps + j)*c_group_w +: c_group_w] = w_gsum[j];
            end
        end

        assign w_nsum[k] = w_ns;
        assign w_sa[k]   = w_a;
        assign w_sb[k]   = w_b;
        assign w_nco[k]  = w_gc[c_gps];
    end

    assign w_novf  = (w_sa[STAGES-1][WIDTH-1] == w_sb[STAGES-1][WIDTH-1])
                  && (w_nsum[STAGES-1][WIDTH-1] != w_sa[STAGES-1][WIDTH-1]);
    assign w_nzero = (w_nsum[STAGES-1] == '0);

    // A stage may load when it or any stage downstream of it has a hole,
    // or when the output is being taken this cycle.
    always_comb begin
        w_vin    = '0;
        w_adv    = '0;
        w_vin[0] = in_valid;
        for (int k = 1; k < STAGES; k++) w_vin[k] = r_vld[k-1];
        for (int k = 0; k < STAGES; k++) begin
            w_adv[k] = out_ready;
            for (int j = k; j < STAGES; j++) begin
                if (!r_vld[j]) w_adv[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_vld  <= '0;
            r_c    <= '0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                r_sum[k] <= '0;
                r_a[k]   <= '0;
                r_b[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_adv[k]) begin
                    r_vld[k] <= w_vin[k];
                    if (w_vin[k]) begin
                        r_sum[k] <= w_nsum[k];
                        r_a[k]   <= w_sa[k];
                        r_b[k]   <= w_sb[k];
                        r_c[k]   <= w_nco[k];
                    end
                end
            end
            if (w_adv[STAGES-1] && w_vin[STAGES-1]) begin
                r_ovf  <= w_novf;
                r_zero <= w_nzero;
            end
        end
    end

    assign in_ready  = w_adv[0];
    assign out_valid = r_vld[STAGES-1];
    assign sum       = r_sum[STAGES-1];
    assign cout      = r_c[STAGES-1];
    assign ovf       = r_ovf;
    assign zero      = r_zero;

endmodule
`default_nettype wire
